// File: rtl/simon_pkg.sv
// Shared types for the Simon sequence player: colour codes, player
// states and the colour-to-LED one-hot helper.
package simon_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        BLUE   = 2'd2,
        YELLOW = 2'd3
    } color_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } play_state_t;

    function automatic logic [3:0] color_to_led(input color_t c);
        return 4'b0001 << c;
    endfunction

endpackage

// File: rtl/tick_counter.sv
// Phase tick counter for the Simon player.
// Ports: clk, reset (async active-low), clear_i (sync clear, wins over
// tick_i), tick_i (count enable), limit_i (phase length in ticks),
// tc_o (high on the tick that completes the phase).
module tick_counter #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         tick_i,
    input  logic [W-1:0] limit_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W:0]   cnt_nx;

    assign cnt_nx = {1'b0, cnt_q} + {{W{1'b0}}, 1'b1};

    // Terminal count fires on the tick that brings the count up to the limit.
    assign tc_o = tick_i && (cnt_nx >= {1'b0, limit_i});

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (tick_i && (cnt_q != '1)) begin
            // Saturate rather than wrap.
            cnt_d = cnt_nx[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/simon_sequence_player.sv
// Plays a latched Simon colour sequence on four one-hot LEDs, paced by
// timer ticks (ON_TICKS lit, GAP_TICKS dark per step).
// Ports: clk, reset (async active-low), start/seq_len/seq_data (request),
// tick (timer pulse), tmr_clear (timer reload), busy, done, led.
// Optional macro SIMON_TONE_EN adds tone_sel (lit colour) and tone_on.
module simon_sequence_player
    import simon_pkg::*;
#(
    parameter int MAX_LEN   = 32,
    parameter int ON_TICKS  = 2,
    parameter int GAP_TICKS = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [$clog2(MAX_LEN+1)-1:0] seq_len,
    input  logic [2*MAX_LEN-1:0]         seq_data,
    input  logic                         tick,
    output logic                         tmr_clear,
    output logic                         busy,
    output logic                         done,
    output logic [3:0]                   led
`ifdef SIMON_TONE_EN
    ,
    output logic [1:0]                   tone_sel,
    output logic                         tone_on
`endif
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int SW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int MT = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
    localparam int CW = $clog2(MT + 1);

    play_state_t     state_q;
    color_t          seq_q [MAX_LEN];
    logic [LW-1:0]   len_q;
    logic [SW-1:0]   step_q;
    logic [SW-1:0]   step_nx;
    logic [3:0]      led_q;
    logic            busy_q;
    logic            done_q;
    logic            clr_q;

    logic            accept;
    logic            in_play;
    logic            ph_tick;
    logic            ph_tc;
    logic            cnt_clr;
    logic            last;
    logic [CW-1:0]   limit;
    logic [LW-1:0]   len_c;

    assign accept  = (state_q == IDLE) && start;
    assign in_play = (state_q == ON) || (state_q == GAP);
    // Ticks outside ON/GAP (including one coinciding with start) never count.
    assign ph_tick = in_play && tick;
    assign cnt_clr = accept || ph_tc;
    assign limit   = (state_q == ON) ? CW'(ON_TICKS) : CW'(GAP_TICKS);
    assign len_c   = (seq_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : seq_len;
    assign last    = (LW'(step_q) == (len_q - LW'(1)));
    assign step_nx = step_q + SW'(1);

    tick_counter #(
        .W (CW)
    ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear_i (cnt_clr),
        .tick_i  (ph_tick),
        .limit_i (limit),
        .tc_o    (ph_tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            step_q  <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            clr_q   <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seq_q[i] <= RED;
            end
        end else begin
            done_q <= 1'b0;
            clr_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (seq_len != '0) begin
                            for (int i = 0; i < MAX_LEN; i++) begin
                                seq_q[i] <= color_t'(seq_data[2*i +: 2]);
                            end
                            len_q   <= len_c;
                            step_q  <= '0;
                            clr_q   <= 1'b1;
                            busy_q  <= 1'b1;
                            // Step 0 comes straight from the input being latched.
                            led_q   <= color_to_led(color_t'(seq_data[1:0]));
                            state_q <= ON;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ON: begin
                    if (ph_tc) begin
                        led_q   <= '0;
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    if (ph_tc) begin
                        if (last) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            step_q  <= step_nx;
                            led_q   <= color_to_led(seq_q[step_nx]);
                            state_q <= ON;
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign led       = led_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign tmr_clear = clr_q;

`ifdef SIMON_TONE_EN
    // Encode the one-hot LED back to its colour; dark reads as 0.
    assign tone_sel = {led_q[3] | led_q[2], led_q[3] | led_q[1]};
    assign tone_on  = |led_q;
`endif

endmodule

// File: tb/tb_simon_sequence_player.sv
// Self-checking bench for simon_sequence_player: scoreboard of expected
// LED phases keyed by tick count, plus reset, zero-length and clamp cases.
module tb_simon_sequence_player;

    localparam int ON  = 2;
    localparam int GAP = 1;

    typedef struct {
        logic [3:0] led;
        int         tick;
        logic [1:0] code;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  seq_len;
    logic [63:0] seq_data;
    logic        tick;
    logic        tmr_clear;
    logic        busy;
    logic        done;
    logic [3:0]  led;
`ifdef SIMON_TONE_EN
    logic [1:0]  tone_sel;
    logic        tone_on;
`endif

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    simon_sequence_player #(
        .MAX_LEN   (32),
        .ON_TICKS  (ON),
        .GAP_TICKS (GAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .seq_len   (seq_len),
        .seq_data  (seq_data),
        .tick      (tick),
        .tmr_clear (tmr_clear),
        .busy      (busy),
        .done      (done),
        .led       (led)
`ifdef SIMON_TONE_EN
        ,
        .tone_sel  (tone_sel),
        .tone_on   (tone_on)
`endif
    );

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        tick = 1'b0;
        seq_len = '0;
        seq_data = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({led, busy, done, tmr_clear} !== 7'b0) begin
            errors++;
            $display("FAIL reset_state got %b, expected 0000000",
                     {led, busy, done, tmr_clear});
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({led, busy, done, tmr_clear} !== 7'b0) begin
            errors++;
            $display("FAIL idle_after_reset got %b, expected 0000000",
                     {led, busy, done, tmr_clear});
        end
    endtask

    // Drives one start and plays it out, checking against the scoreboard.
    task automatic play(input logic [5:0] len, input logic [63:0] data,
                        input int exp_len, input bit tick_w_start,
                        input bit restart, input int period);
        exp_t e;
        logic [1:0] code;
        logic [3:0] prev;
        int ticks = 0;
        int done_cnt = 0;
        int clr_cnt = 0;
        int done_c = -1;
        int done_ticks = -1;
        bit done_tick_now = 0;
        bit tick_now;
        bit exp_busy;
        bit fin = 0;
        sb.delete();
        for (int i = 0; i < exp_len; i++) begin
            code = data[2*i +: 2];
            e.led = 4'b0001 << code;
            e.tick = i * (ON + GAP);
            e.code = code;
            sb.push_back(e);
            e.led = 4'b0000;
            e.tick = i * (ON + GAP) + ON;
            sb.push_back(e);
        end
        prev = led;
        start = 1'b1;
        seq_len = len;
        seq_data = data;
        tick = tick_w_start;
        for (int c = 0; c < 2000 && !fin; c++) begin
            @(negedge clk);
            tick_now = (c > 0) && tick;
            if (tick_now) ticks++;
            start = 1'b0;
            tick = 1'b0;
            if (done) begin
                done_cnt++;
                if (done_c < 0) begin
                    done_c = c;
                    done_ticks = ticks;
                    done_tick_now = tick_now;
                end
            end
            if (tmr_clear) clr_cnt++;
            exp_busy = (exp_len != 0) && (done_c < 0);
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL busy cyc=%0d got %b, expected %b",
                         c, busy, exp_busy);
            end
            if (led !== prev) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL led_extra got %b at tick %0d, expected none",
                             led, ticks);
                end else begin
                    e = sb.pop_front();
                    if (led !== e.led || ticks != e.tick) begin
                        errors++;
                        $display("FAIL led_seq got %b@tick%0d, expected %b@tick%0d",
                                 led, ticks, e.led, e.tick);
                    end
`ifdef SIMON_TONE_EN
                    checks++;
                    if (tone_on !== (e.led != 4'b0) ||
                        (e.led != 4'b0 && tone_sel !== e.code)) begin
                        errors++;
                        $display("FAIL tone got sel=%0d on=%b, expected sel=%0d on=%b",
                                 tone_sel, tone_on, e.code, e.led != 4'b0);
                    end
`endif
                end
                prev = led;
            end
            if (done_c >= 0) begin
                if (c >= done_c + 3) fin = 1;
            end else begin
                tick = ((c + 1) % period) == 0;
                if (restart && c == 5) begin
                    start = 1'b1;
                    seq_len = 6'd2;
                    seq_data = ~data;
                end
            end
        end
        tick = 1'b0;
        checks++;
        if (done_c < 0) begin
            errors++;
            $display("FAIL done_timeout got no done, expected one");
        end else if (exp_len == 0) begin
            if (done_c != 0) begin
                errors++;
                $display("FAIL done_zero_len got cyc %0d, expected cyc 0", done_c);
            end
        end else if (done_ticks != exp_len * (ON + GAP) || !done_tick_now) begin
            errors++;
            $display("FAIL done_time got tick %0d (fresh=%b), expected tick %0d (fresh=1)",
                     done_ticks, done_tick_now, exp_len * (ON + GAP));
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL done_count got %0d, expected 1", done_cnt);
        end
        checks++;
        if (clr_cnt != ((exp_len != 0) ? 1 : 0)) begin
            errors++;
            $display("FAIL tmr_clear_count got %0d, expected %0d",
                     clr_cnt, (exp_len != 0) ? 1 : 0);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d entries pending, expected 0",
                     sb.size());
        end
    endtask

    task automatic test_basic();
        play(6'd3, 64'h24, 3, 1'b0, 1'b0, 4);
    endtask

    task automatic test_zero_len();
        play(6'd0, 64'h24, 0, 1'b0, 1'b0, 4);
    endtask

    task automatic test_start_while_busy();
        play(6'd3, 64'h1B, 3, 1'b0, 1'b1, 4);
    endtask

    task automatic test_tick_with_start();
        play(6'd2, 64'h9, 2, 1'b1, 1'b0, 4);
    endtask

    task automatic test_clamp();
        logic [63:0] d;
        d = {$urandom(), $urandom()};
        play(6'd63, d, 32, 1'b0, 1'b0, 2);
    endtask

`ifdef SIMON_TONE_EN
    task automatic test_tone();
        play(6'd1, 64'h3, 1, 1'b0, 1'b0, 4);
    endtask
`endif

    task automatic test_reset_midplay();
        int n = 0;
        start = 1'b1;
        seq_len = 6'd3;
        seq_data = 64'h24;
        tick = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (led !== 4'b0100 && n < 200) begin
            tick = (n % 2) == 1;
            @(negedge clk);
            n++;
        end
        tick = 1'b0;
        checks++;
        if (led !== 4'b0100) begin
            errors++;
            $display("FAIL reach_blue got %b, expected 0100", led);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (led !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got led=%b busy=%b, expected led=0000 busy=0",
                     led, busy);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || tmr_clear !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_done got done=%b clr=%b, expected 0 0",
                         done, tmr_clear);
            end
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({led, busy, done} !== 6'b0) begin
                errors++;
                $display("FAIL idle_after_midreset got %b, expected 000000",
                         {led, busy, done});
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_start_while_busy();
        test_tick_with_start();
        test_clamp();
`ifdef SIMON_TONE_EN
        test_tone();
`endif
        test_reset_midplay();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
